// File: rtl/cache_mem_pkg.sv
// Shared types for the cache/memory arbiter: FSM states, requester ids, line width
// and the latched transaction record.
package cache_mem_pkg;

  localparam int   LINE_WIDTH = 256;
  localparam logic REQ_I      = 1'b0;
  localparam logic REQ_D      = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_e;

  typedef struct packed {
    logic        id;
    logic        write;
    logic [31:0] address;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        in_range;
  } arb_txn_t;

endpackage

// File: rtl/cache_memory_arbiter_if.sv
// Requester (I/D cache) and memory-side signals of the arbiter.
// master = arbiter, slave = cache controllers plus memory.
interface cache_memory_arbiter_if;
  import cache_mem_pkg::*;

  logic                  i_req;
  logic [31:0]           i_address;
  logic                  i_done;
  logic                  i_error;
  logic [LINE_WIDTH-1:0] i_line;

  logic                  d_req;
  logic                  d_write;
  logic [31:0]           d_address;
  logic [31:0]           d_write_data;
  logic [3:0]            d_write_mask;
  logic                  d_done;
  logic                  d_error;
  logic [LINE_WIDTH-1:0] d_line;

  logic                  mem_write_enable;
  logic [31:0]           mem_address;
  logic [31:0]           mem_write_data;
  logic [3:0]            mem_write_mask;
  logic [LINE_WIDTH-1:0] mem_read_data;

  logic                  busy;

  modport master (
    input  i_req, i_address,
    output i_done, i_error, i_line,
    input  d_req, d_write, d_address, d_write_data, d_write_mask,
    output d_done, d_error, d_line,
    output mem_write_enable, mem_address, mem_write_data, mem_write_mask,
    input  mem_read_data,
    output busy
  );

  modport slave (
    output i_req, i_address,
    input  i_done, i_error, i_line,
    output d_req, d_write, d_address, d_write_data, d_write_mask,
    input  d_done, d_error, d_line,
    input  mem_write_enable, mem_address, mem_write_data, mem_write_mask,
    output mem_read_data,
    input  busy
  );

endinterface

// File: rtl/cache_mem_rr_picker.sv
// 2-way round-robin picker: a lone request wins, on a tie the side not granted last wins.
// Purely combinational; no backpressure of its own.
module cache_mem_rr_picker
  import cache_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_vld,
  output logic       grant_id
);

  assign grant_vld = |req;
  assign grant_id  = (req[REQ_D] && (!req[REQ_I] || last_grant == REQ_I)) ? REQ_D : REQ_I;

endmodule

// File: rtl/cache_memory_arbiter.sv
// Shares the block-read/word-write data memory between I-cache refills and D-cache reads/writes.
// Grant in IDLE, memory access in ISSUE, done in RESP (3 cycles); requests are levels held until done.
module cache_memory_arbiter
  import cache_mem_pkg::*;
#(
  parameter int VALID_ADDRESS_WIDTH = 18
) (
  input  logic                   clk,
  input  logic                   reset_n,
  cache_memory_arbiter_if.master bus
);

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  arb_txn_t   txn_q, txn_d;
  logic       grant_vld, grant_id;
  logic       in_issue, in_resp, rd_ok;

  function automatic logic addr_in_range(input logic [31:0] addr);
    return (addr >> (VALID_ADDRESS_WIDTH + 2)) == 32'd0;
  endfunction

  cache_mem_rr_picker u_picker (
    .req        ({bus.d_req, bus.i_req}),
    .last_grant (last_grant_q),
    .grant_vld  (grant_vld),
    .grant_id   (grant_id)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_D;
      txn_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      txn_q        <= txn_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    txn_d        = txn_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d      = ISSUE;
          last_grant_d = grant_id;
          txn_d        = '0;
          txn_d.id     = grant_id;
          if (grant_id == REQ_D) begin
            txn_d.write   = bus.d_write;
            txn_d.address = bus.d_address;
            txn_d.data    = bus.d_write_data;
            txn_d.mask    = bus.d_write_mask;
          end else begin
            txn_d.address = bus.i_address;
          end
          txn_d.in_range = addr_in_range(txn_d.address);
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Everything below decodes registered state only, so reset clears it asynchronously.
  assign in_issue = (state_q == ISSUE);
  assign in_resp  = (state_q == RESP);
  assign rd_ok    = in_resp && !txn_q.write && txn_q.in_range;

  assign bus.mem_write_enable = in_issue && txn_q.write && txn_q.in_range;
  assign bus.mem_address      = in_issue ? txn_q.address : 32'd0;
  assign bus.mem_write_data   = in_issue ? txn_q.data    : 32'd0;
  assign bus.mem_write_mask   = in_issue ? txn_q.mask    : 4'd0;

  assign bus.i_done  = in_resp && (txn_q.id == REQ_I);
  assign bus.i_error = bus.i_done && !txn_q.in_range;
  assign bus.i_line  = (rd_ok && txn_q.id == REQ_I) ? bus.mem_read_data : '0;

  assign bus.d_done  = in_resp && (txn_q.id == REQ_D);
  assign bus.d_error = bus.d_done && !txn_q.in_range;
  assign bus.d_line  = (rd_ok && txn_q.id == REQ_D) ? bus.mem_read_data : '0;

  assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_cache_memory_arbiter.sv
// Bench for cache_memory_arbiter: directed vector table, tie/reset sequences and a
// randomized run checked against a transaction-level model with a shadow memory.
module tb_cache_memory_arbiter;
  import cache_mem_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cache_memory_arbiter_if bus();

  cache_memory_arbiter #(.VALID_ADDRESS_WIDTH(18)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural DataMemoryForCache: registered 256-bit line read, masked word write.
  logic [31:0]  mem [0:(1<<18)-1];
  logic [255:0] rd_line;
  logic [17:0]  mem_w;
  assign mem_w             = bus.mem_address[19:2];
  assign bus.mem_read_data = rd_line;

  always @(posedge clk) begin
    if (bus.mem_write_enable)
      for (int b = 0; b < 4; b++)
        if (bus.mem_write_mask[b]) mem[mem_w][8*b +: 8] = bus.mem_write_data[8*b +: 8];
    for (int k = 0; k < 8; k++) rd_line[32*k +: 32] <= mem[{mem_w[17:3], 3'(k)}];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         side;
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  data;
    logic [3:0]   mask;
    logic         exp_err;
    logic         exp_we;
    logic [255:0] exp_line;
  } vec_t;

  vec_t vecs [8];

  task automatic idle_inputs();
    bus.i_req = 0; bus.i_address = 0;
    bus.d_req = 0; bus.d_write = 0; bus.d_address = 0; bus.d_write_data = 0; bus.d_write_mask = 0;
  endtask

  // Issue one transaction from IDLE and check timing and response.
  task automatic run_txn(input vec_t v, input int idx);
    int           done_cyc = -1;
    int           we_cnt = 0;
    int           we_cyc = -1;
    logic         err = 0;
    logic         other = 0;
    logic [255:0] line = '0;
    logic [31:0]  issue_addr = '0;
    if (v.side == REQ_I) begin
      bus.i_req = 1; bus.i_address = v.addr;
    end else begin
      bus.d_req = 1; bus.d_write = v.wr; bus.d_address = v.addr;
      bus.d_write_data = v.data; bus.d_write_mask = v.mask;
    end
    for (int c = 1; c <= 6 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (bus.mem_write_enable) begin we_cnt++; we_cyc = c; end
      if (c == 1) issue_addr = bus.mem_address;
      if (v.side == REQ_I ? bus.i_done : bus.d_done) begin
        done_cyc = c;
        err   = (v.side == REQ_I) ? bus.i_error : bus.d_error;
        line  = (v.side == REQ_I) ? bus.i_line  : bus.d_line;
        other = (v.side == REQ_I) ? bus.d_done  : bus.i_done;
      end
    end
    idle_inputs();
    @(posedge clk); #1;
    chk($sformatf("v%0d done_cycle", idx), done_cyc, 2);
    chk($sformatf("v%0d error", idx), err, v.exp_err);
    chk($sformatf("v%0d line", idx), line, v.exp_line);
    chk($sformatf("v%0d other_done", idx), other, 1'b0);
    chk($sformatf("v%0d we_count", idx), we_cnt, v.exp_we ? 1 : 0);
    if (v.exp_we) chk($sformatf("v%0d we_cycle", idx), we_cyc, 1);
    chk($sformatf("v%0d issue_addr", idx), issue_addr, v.addr);
    chk($sformatf("v%0d busy_after", idx), bus.busy, 1'b0);
  endtask

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return $urandom | 32'h0010_0000;
    return 32'($urandom_range(0, 1023));
  endfunction

  // Random-phase model state
  logic [31:0]  shadow [0:255];
  logic         lg, have, t_side, t_wr, t_err, issue, resp;
  logic [31:0]  t_addr, t_data;
  logic [3:0]   t_mask;
  logic [255:0] t_line, line_a, line_b;
  logic [7:0]   wi;
  int           next_free, g_edge, done_cyc;

  initial begin
    for (int i = 0; i < (1<<18); i++) mem[i] = 32'd0;
    for (int k = 0; k < 8; k++) mem[16 + k] = 32'h10 + k;
    for (int k = 0; k < 8; k++) line_a[32*k +: 32] = 32'h10 + k;
    line_b = line_a;
    line_b[63:32] = 32'h00BB_00DD;

    vecs[0] = '{REQ_I, 1'b0, 32'h0000_0040, 32'h0,         4'b0000, 1'b0, 1'b0, line_a};
    vecs[1] = '{REQ_D, 1'b1, 32'h0000_0044, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b1, 256'h0};
    vecs[2] = '{REQ_D, 1'b0, 32'h0000_0040, 32'h0,         4'b0000, 1'b0, 1'b0, line_b};
    vecs[3] = '{REQ_D, 1'b1, 32'h0040_0000, 32'hDEAD_BEEF, 4'b1111, 1'b1, 1'b0, 256'h0};
    vecs[4] = '{REQ_D, 1'b1, 32'h0000_0048, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b1, 256'h0};
    vecs[5] = '{REQ_D, 1'b0, 32'h0000_0040, 32'h0,         4'b0000, 1'b0, 1'b0, line_b};
    vecs[6] = '{REQ_I, 1'b0, 32'hFFFF_FFE0, 32'h0,         4'b0000, 1'b1, 1'b0, 256'h0};
    vecs[7] = '{REQ_D, 1'b0, 32'h0000_0000, 32'h0,         4'b0000, 1'b0, 1'b0, 256'h0};

    // Reset values, with both requests already high.
    reset_n = 0;
    idle_inputs();
    bus.i_req = 1; bus.i_address = 32'h40;
    bus.d_req = 1; bus.d_address = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", bus.busy, 1'b0);
    chk("rst done_err", {bus.i_done, bus.i_error, bus.d_done, bus.d_error}, 4'b0);
    chk("rst i_line", bus.i_line, '0);
    chk("rst d_line", bus.d_line, '0);
    chk("rst mem_out", {bus.mem_write_enable, bus.mem_address, bus.mem_write_data, bus.mem_write_mask}, '0);
    @(negedge clk);
    reset_n = 1;

    // Continuous tie: I wins first, then strict alternation every 3 cycles.
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      chk($sformatf("tie c%0d i_done", c), bus.i_done, (c == 2 || c == 8));
      chk($sformatf("tie c%0d d_done", c), bus.d_done, (c == 5 || c == 11));
    end
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    for (int n = 0; n < 8; n++) run_txn(vecs[n], n);
    chk("mem word0 untouched", mem[0], 32'h0);
    chk("mem mask0 untouched", mem[18], 32'h12);

    // Reset during the ISSUE cycle of a write; request stays held across reset.
    bus.d_req = 1; bus.d_write = 1; bus.d_address = 32'h60;
    bus.d_write_data = 32'h1122_3344; bus.d_write_mask = 4'b1111;
    @(posedge clk); #1;
    chk("rstmid we_in_issue", bus.mem_write_enable, 1'b1);
    #2 reset_n = 0;
    #1;
    chk("rstmid we_dropped", bus.mem_write_enable, 1'b0);
    chk("rstmid busy", bus.busy, 1'b0);
    chk("rstmid mem_unwritten", mem[24], 32'h0);
    @(negedge clk);
    reset_n = 1;
    done_cyc = -1;
    for (int c = 1; c <= 5 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (bus.d_done || bus.i_done) done_cyc = c;
    end
    chk("rstmid reissue_done_cycle", done_cyc, 2);
    chk("rstmid reissue_d_done", bus.d_done, 1'b1);
    idle_inputs();
    @(posedge clk); #1;
    chk("rstmid mem_written", mem[24], 32'h1122_3344);

    // Randomized traffic against a transaction-level model.
    reset_n = 0;
    #3 reset_n = 1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    lg = REQ_D; have = 0; next_free = 0; g_edge = 0;
    t_side = 0; t_wr = 0; t_err = 0; t_addr = 0; t_data = 0; t_mask = 0; t_line = '0;
    for (int e = 1; e <= 3000; e++) begin
      @(posedge clk);
      if (e >= next_free && (bus.i_req || bus.d_req)) begin
        t_side = bus.d_req && (!bus.i_req || lg == REQ_I);
        if (t_side == REQ_D) begin
          t_wr = bus.d_write; t_addr = bus.d_address; t_data = bus.d_write_data; t_mask = bus.d_write_mask;
        end else begin
          t_wr = 0; t_addr = bus.i_address; t_data = 0; t_mask = 0;
        end
        t_err  = (t_addr >= 32'h0010_0000);
        t_line = '0;
        if (!t_err) begin
          wi = t_addr[9:2];
          if (t_wr) begin
            for (int b = 0; b < 4; b++) if (t_mask[b]) shadow[wi][8*b +: 8] = t_data[8*b +: 8];
          end else begin
            for (int k = 0; k < 8; k++) t_line[32*k +: 32] = shadow[{t_addr[9:5], 3'(k)}];
          end
        end
        g_edge = e; next_free = e + 3; have = 1; lg = t_side;
      end
      #1;
      issue = have && (e == g_edge);
      resp  = have && (e == g_edge + 1);
      chk($sformatf("rnd%0d busy", e), bus.busy, have && (e - g_edge) <= 1);
      chk($sformatf("rnd%0d we", e), bus.mem_write_enable, issue && t_wr && !t_err);
      chk($sformatf("rnd%0d mem_address", e), bus.mem_address, issue ? t_addr : 32'h0);
      if (!(issue && t_side == REQ_I))
        chk($sformatf("rnd%0d mem_data_mask", e), {bus.mem_write_data, bus.mem_write_mask},
            issue ? {t_data, t_mask} : 36'h0);
      chk($sformatf("rnd%0d i_done_err", e), {bus.i_done, bus.i_error},
          {resp && t_side == REQ_I, resp && t_side == REQ_I && t_err});
      chk($sformatf("rnd%0d d_done_err", e), {bus.d_done, bus.d_error},
          {resp && t_side == REQ_D, resp && t_side == REQ_D && t_err});
      chk($sformatf("rnd%0d i_line", e), bus.i_line,
          (resp && t_side == REQ_I && !t_err) ? t_line : 256'h0);
      chk($sformatf("rnd%0d d_line", e), bus.d_line,
          (resp && t_side == REQ_D && !t_err && !t_wr) ? t_line : 256'h0);
      if (!bus.i_req || (resp && t_side == REQ_I)) begin
        bus.i_req = ($urandom_range(0, 2) != 0);
        bus.i_address = rnd_addr();
      end
      if (!bus.d_req || (resp && t_side == REQ_D)) begin
        bus.d_req = ($urandom_range(0, 2) != 0);
        bus.d_write = $urandom_range(0, 1) != 0;
        bus.d_address = rnd_addr();
        bus.d_write_data = $urandom;
        bus.d_write_mask = 4'($urandom_range(0, 15));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
